// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, PC step and fetch FSM states.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding imem request, one-entry skid buffer in front
// of the IF/ID handshake, redirect flushes everything in flight.
//
// state | meaning
// REQ   | issue request at fetch_pc (suppressed while redirect_i is high)
// WAIT  | request outstanding, response will be delivered
// DROP  | request outstanding, response will be discarded (redirected)
// HOLD  | response parked in skid register, outputs still stalled
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic [XLEN-1:0] inst_o
);

    fetch_state_e    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc4;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_pc4;
    logic [XLEN-1:0] skid_inst;
    logic            out_free;

    assign fetch_pc4   = fetch_pc + PC_INC;
    assign out_free    = !valid_o || ready_i;
    assign imem_req_o  = rst_i && (state == ST_REQ) && !redirect_i;
    assign imem_addr_o = fetch_pc;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= ST_REQ;
            fetch_pc  <= RESET_PC;
            valid_o   <= 1'b0;
            pc_o      <= '0;
            pc4_o     <= '0;
            inst_o    <= '0;
            skid_pc   <= '0;
            skid_pc4  <= '0;
            skid_inst <= '0;
        end else begin
            if (valid_o && ready_i) valid_o <= 1'b0;
            if (redirect_i) fetch_pc <= align_pc(redirect_pc_i);

            case (state)
                ST_REQ: begin
                    if (!redirect_i) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (redirect_i) begin
                        state <= imem_rvalid_i ? ST_REQ : ST_DROP;
                    end else if (imem_rvalid_i) begin
                        fetch_pc <= fetch_pc4;
                        if (out_free) begin
                            valid_o <= 1'b1;
                            pc_o    <= fetch_pc;
                            pc4_o   <= fetch_pc4;
                            inst_o  <= imem_rdata_i;
                            state   <= ST_REQ;
                        end else begin
                            skid_pc   <= fetch_pc;
                            skid_pc4  <= fetch_pc4;
                            skid_inst <= imem_rdata_i;
                            state     <= ST_HOLD;
                        end
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid_i) state <= ST_REQ;
                end
                ST_HOLD: begin
                    if (redirect_i) begin
                        state <= ST_REQ;
                    end else if (ready_i) begin
                        valid_o <= 1'b1;
                        pc_o    <= skid_pc;
                        pc4_o   <= skid_pc4;
                        inst_o  <= skid_inst;
                        state   <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase

            // A redirect flushes the IF/ID slot regardless of any load above.
            if (redirect_i) valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: instruction-stream model (sequential PCs, restarted by
// redirect/reset) checked every cycle, plus directed scenarios with literal results.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC0 = 32'h0000_0000;
    localparam logic [31:0] RST_PC1 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_i, imem_req_o, imem_rvalid_i, redirect_i, ready_i, valid_o;
    logic [31:0] imem_addr_o, imem_rdata_i, redirect_pc_i, pc_o, pc4_o, inst_o;

    logic        req1, rvalid1, redirect1, ready1, valid1;
    logic [31:0] addr1, rdata1, redirect_pc1, pc1, pc41, inst1;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RST_PC0)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .ready_i(ready_i), .valid_o(valid_o),
        .pc_o(pc_o), .pc4_o(pc4_o), .inst_o(inst_o)
    );

    inst_fetch #(.RESET_PC(RST_PC1)) dut_wrap (
        .clk_i(clk), .rst_i(rst_i),
        .imem_req_o(req1), .imem_addr_o(addr1),
        .imem_rvalid_i(rvalid1), .imem_rdata_i(rdata1),
        .redirect_i(redirect1), .redirect_pc_i(redirect_pc1),
        .ready_i(ready1), .valid_o(valid1),
        .pc_o(pc1), .pc4_o(pc41), .inst_o(inst1)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;
    int lat   = 1;

    // memory responder state
    logic        pend_valid = 1'b0;
    logic        pend_redir = 1'b0;
    logic [31:0] pend_addr  = '0;
    int          pend_cnt   = 0;
    logic        nxt_rv     = 1'b0;
    logic [31:0] nxt_rd     = '0;
    logic        r1_next    = 1'b0;
    logic [31:0] a1         = '0;

    // stream model
    logic [31:0] exp_pc  = RST_PC0;
    logic [31:0] exp_req = RST_PC0;
    logic        prev_rst = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_redir = 1'b0;
    logic [31:0] prev_pc = '0, prev_pc4 = '0, prev_inst = '0;

    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];
    logic [31:0] dlv_pc_q[$], dlv_pc4_q[$], dlv_inst_q[$];
    int          dlv_cyc_q[$];
    logic [31:0] r1_q[$], d1_pc_q[$], d1_pc4_q[$];
    int          b_req = 0, b_dlv = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc_n);
        end
    endfunction

    function automatic void chk1(input string nm, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, got, exp, cyc_n);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_i) begin
            chk1("req_low_in_reset", imem_req_o, 1'b0);
            exp_pc  = RST_PC0;
            exp_req = RST_PC0;
            if (pend_valid) pend_redir = 1'b1;
        end else begin
            if (!prev_rst) begin
                chk1("reset_valid", valid_o, 1'b0);
                chk("reset_pc", pc_o, 32'd0);
                chk("reset_pc4", pc4_o, 32'd0);
                chk("reset_inst", inst_o, 32'd0);
                chk1("req_after_reset", imem_req_o, !redirect_i);
            end else if (prev_redir) begin
                chk1("valid_cleared_by_redirect", valid_o, 1'b0);
            end else if (prev_valid && !prev_ready) begin
                chk1("stall_valid", valid_o, 1'b1);
                chk("stall_pc", pc_o, prev_pc);
                chk("stall_pc4", pc4_o, prev_pc4);
                chk("stall_inst", inst_o, prev_inst);
            end
            if (redirect_i) chk1("req_blocked_by_redirect", imem_req_o, 1'b0);
            if (pend_valid && !pend_redir) chk("addr_stable", imem_addr_o, pend_addr);
            if (imem_req_o) begin
                chk1("single_outstanding", pend_valid, 1'b0);
                chk("req_addr", imem_addr_o, exp_req);
                exp_req = exp_req + 32'd4;
                req_addr_q.push_back(imem_addr_o);
                req_cyc_q.push_back(cyc_n);
                pend_valid = 1'b1;
                pend_redir = 1'b0;
                pend_addr  = imem_addr_o;
                pend_cnt   = lat;
            end
            if (valid_o && ready_i && !redirect_i) begin
                chk("dlv_pc", pc_o, exp_pc);
                chk("dlv_pc4", pc4_o, exp_pc + 32'd4);
                chk("dlv_inst", inst_o, mem_word(exp_pc));
                dlv_pc_q.push_back(pc_o);
                dlv_pc4_q.push_back(pc4_o);
                dlv_inst_q.push_back(inst_o);
                dlv_cyc_q.push_back(cyc_n);
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_i) begin
                exp_pc  = redirect_pc_i & 32'hFFFF_FFFC;
                exp_req = exp_pc;
                if (pend_valid) pend_redir = 1'b1;
            end
        end
        nxt_rv = 1'b0;
        nxt_rd = 32'hDEAD_BEEF;
        if (pend_valid) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                nxt_rv     = 1'b1;
                nxt_rd     = mem_word(pend_addr);
                pend_valid = 1'b0;
            end
        end
        prev_rst   = rst_i;
        prev_valid = valid_o;
        prev_ready = ready_i;
        prev_redir = redirect_i;
        prev_pc    = pc_o;
        prev_pc4   = pc4_o;
        prev_inst  = inst_o;
        cyc_n++;
    end

    // second instance: fixed 1-cycle memory, always ready, never redirected
    always @(negedge clk) begin
        if (req1) r1_q.push_back(addr1);
        if (valid1) begin
            d1_pc_q.push_back(pc1);
            d1_pc4_q.push_back(pc41);
        end
        r1_next = req1;
        a1      = addr1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        imem_rvalid_i = nxt_rv;
        imem_rdata_i  = nxt_rd;
        rvalid1       = r1_next;
        rdata1        = mem_word(a1);
        redirect_i    = 1'b0;
    endtask

    task automatic take_base();
        b_req = req_addr_q.size();
        b_dlv = dlv_pc_q.size();
    endtask

    // Leaves the caller inside the first cycle with rst_i high.
    task automatic reset_dut();
        cyc();
        rst_i   = 1'b0;
        ready_i = 1'b1;
        lat     = 1;
        cyc();
        cyc();
        rst_i = 1'b1;
        take_base();
    endtask

    initial begin
        rst_i = 1'b0; ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        rvalid1 = 1'b0; rdata1 = '0; redirect1 = 1'b0; redirect_pc1 = '0; ready1 = 1'b1;

        // streaming, 1-cycle memory, always ready
        reset_dut();
        repeat (12) cyc();
        chk("t1_req0", req_addr_q[b_req], 32'h0);
        chk("t1_req1", req_addr_q[b_req+1], 32'h4);
        chk("t1_req2", req_addr_q[b_req+2], 32'h8);
        chk("t1_first_pc", dlv_pc_q[b_dlv], 32'h0);
        chk("t1_first_pc4", dlv_pc4_q[b_dlv], 32'h4);
        chk("t1_first_inst", dlv_inst_q[b_dlv], 32'h1357_9BDF);
        chk("t1_spacing", 32'(dlv_cyc_q[b_dlv+1] - dlv_cyc_q[b_dlv]), 32'd2);
        chk("t1_count", 32'(dlv_pc_q.size() - b_dlv), 32'd5);
        chk("wrap_req0", r1_q[0], 32'hFFFF_FFFC);
        chk("wrap_req1", r1_q[1], 32'h0);
        chk("wrap_first_pc", d1_pc_q[0], 32'hFFFF_FFFC);
        chk("wrap_first_pc4", d1_pc4_q[0], 32'h0);

        // backpressure: second response parked in skid
        reset_dut();
        ready_i = 1'b0;
        repeat (5) cyc();
        ready_i = 1'b1;
        repeat (8) cyc();
        chk("t2_pc0", dlv_pc_q[b_dlv], 32'h0);
        chk("t2_pc1", dlv_pc_q[b_dlv+1], 32'h4);
        chk("t2_inst1", dlv_inst_q[b_dlv+1], 32'h1357_9BDB);
        chk("t2_b2b", 32'(dlv_cyc_q[b_dlv+1] - dlv_cyc_q[b_dlv]), 32'd1);
        chk("t2_req2", req_addr_q[b_req+2], 32'h8);
        chk("t2_req2_cyc", 32'(req_cyc_q[b_req+2]), 32'(dlv_cyc_q[b_dlv+1]));

        // redirect while waiting, response 3 cycles after request
        reset_dut();
        lat = 3;
        cyc();
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        repeat (12) cyc();
        chk("t3_req1", req_addr_q[b_req+1], 32'h100);
        chk("t3_req_gap", 32'(req_cyc_q[b_req+1] - req_cyc_q[b_req]), 32'd4);
        chk("t3_pc", dlv_pc_q[b_dlv], 32'h100);
        chk("t3_inst", dlv_inst_q[b_dlv], 32'h1357_9ADF);

        // redirect coincident with response, misaligned target
        reset_dut();
        cyc();
        redirect_i = 1'b1; redirect_pc_i = 32'h203;
        repeat (8) cyc();
        chk("t4_req1", req_addr_q[b_req+1], 32'h200);
        chk("t4_pc", dlv_pc_q[b_dlv], 32'h200);
        chk("t4_inst", dlv_inst_q[b_dlv], 32'h1357_99DF);
        chk("t4_first_dlv_cyc", 32'(dlv_cyc_q[b_dlv] - req_cyc_q[b_req]), 32'd4);

        // one-cycle reset while waiting; stray response lands in REQ
        reset_dut();
        repeat (4) cyc();
        lat = 2;
        cyc();
        rst_i = 1'b0;
        lat = 1;
        cyc();
        rst_i = 1'b1;
        take_base();
        repeat (6) cyc();
        chk("t5_req0", req_addr_q[b_req], 32'h0);
        chk("t5_pc", dlv_pc_q[b_dlv], 32'h0);
        chk("t5_inst", dlv_inst_q[b_dlv], 32'h1357_9BDF);
        chk("t5_latency", 32'(dlv_cyc_q[b_dlv] - req_cyc_q[b_req]), 32'd2);

        // address wrap through redirect near the top of memory
        reset_dut();
        cyc();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF9;
        repeat (8) cyc();
        chk("t6_req1", req_addr_q[b_req+1], 32'hFFFF_FFF8);
        chk("t6_req3", req_addr_q[b_req+3], 32'h0);
        chk("t6_pc4", dlv_pc4_q[b_dlv+1], 32'h0);

        // mixed stalls, redirects and latencies, checked by the stream model
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            cyc();
            ready_i = ($urandom_range(0, 3) != 0);
            lat     = int'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) begin
                redirect_i    = 1'b1;
                redirect_pc_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF5 : $urandom;
            end
        end
        ready_i = 1'b1;
        repeat (10) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the first fetch address after reset.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-low.
REQ-004 imem_req_o  output  1  fetch request strobe, one cycle per fetch.
REQ-005 imem_addr_o  output  32  fetch address, held stable from request until response.
REQ-006 imem_rvalid_i  input  1  response strobe, exactly one per accepted request, earliest one cycle after the request.
REQ-007 imem_rdata_i  input  32  instruction word, valid with imem_rvalid_i.
REQ-008 redirect_i  input  1  branch/jump/flush redirect.
REQ-009 redirect_pc_i  input  32  redirect target.
REQ-010 ready_i  input  1  downstream IF/ID register accepts this cycle.
REQ-011 valid_o  output  1  pc_o/pc4_o/inst_o hold a live instruction.
REQ-012 pc_o  output  32  address of the instruction on inst_o.
REQ-013 pc4_o  output  32  pc_o + 4.
REQ-014 inst_o  output  32  fetched instruction word.

Function
REQ-015 The block SHALL keep one outstanding request at most; fetch_pc is an internal 32-bit register driving imem_addr_o.
REQ-016 FSM states SHALL be REQ, WAIT, DROP and HOLD.
REQ-017 REQ: imem_req_o = !redirect_i. With redirect_i asserted, the block SHALL load fetch_pc <= redirect_pc_i and stay in REQ; otherwise it SHALL go to WAIT.
REQ-018 WAIT with imem_rvalid_i, no redirect, and (!valid_o | ready_i): the block SHALL load outputs {fetch_pc, fetch_pc+4, imem_rdata_i}, set valid_o, set fetch_pc += 4, and go to REQ.
REQ-019 WAIT with imem_rvalid_i, no redirect, valid_o and !ready_i: the block SHALL capture the response into a one-entry skid register, set fetch_pc += 4, and go to HOLD.
REQ-020 WAIT with redirect_i: if imem_rvalid_i is in the same cycle, the block SHALL discard the response and go to REQ; otherwise it SHALL go to DROP. In both cases fetch_pc <= redirect_pc_i.
REQ-021 DROP: the block SHALL discard the pending response. On imem_rvalid_i it SHALL go to REQ. A further redirect_i SHALL only update fetch_pc.
REQ-022 HOLD with redirect_i: the block SHALL discard the skid entry, load fetch_pc <= redirect_pc_i, and go to REQ.
REQ-023 HOLD with ready_i and no redirect: the block SHALL move the skid entry to the outputs with valid_o=1 and go to REQ.
REQ-024 redirect_i SHALL clear valid_o on the next edge in every state, taking priority over ready_i and any load.
REQ-025 valid_o & ready_i with no new load SHALL clear valid_o on the next edge.
REQ-026 While valid_o & !ready_i, pc_o/pc4_o/inst_o SHALL hold.
REQ-027 The block SHALL force redirect_pc_i[1:0] to 2'b00 on capture.
REQ-028 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
REQ-029 Best-case throughput is one instruction per two cycles (request cycle plus one-cycle response).

Reset
REQ-030 With rst_i low at an edge, the block SHALL set state=REQ, fetch_pc=RESET_PC, valid_o=0, pc_o=0, pc4_o=0, inst_o=0, and clear the skid register.
REQ-031 imem_req_o SHALL be 0 while rst_i is low, and SHALL assert in the first cycle after rst_i is sampled high.
REQ-032 Reset mid-request SHALL abandon the request; a late imem_rvalid_i arriving in REQ SHALL be ignored.

Structure
REQ-033 A shared cpu package SHALL hold the FSM state enum, XLEN=32, and the PC increment constant 4.
REQ-034 The FSM and skid register SHALL stay inline; no sub-module.

Verification
REQ-035 Reset release, memory answering every request with 1-cycle latency, ready_i=1 -> requests at 0x0,0x4,0x8. The first valid_o shows pc_o=0, pc4_o=4, inst_o=rdata. There is one instruction every 2 cycles.
REQ-036 ready_i=0 while two responses arrive -> the first is held on the outputs and the second goes to HOLD. When ready_i rises, the outputs show pc_o=0x4 and the next request is at 0x8.
REQ-037 redirect_i to 0x100 while in WAIT, response 3 cycles later -> the response is dropped and valid_o=0. The next request is at 0x100 and the next valid_o shows pc_o=0x100.
REQ-038 redirect_i coincident with imem_rvalid_i in WAIT, target 0x203 -> no output load. The next request is at 0x200.
REQ-039 RESET_PC=32'hFFFF_FFFC -> the second request is at 0x0 and pc4_o of the first instruction is 0x0.
REQ-040 rst_i low for one cycle while in WAIT, with rvalid arriving later -> the outputs are zero, the stray response is ignored, and a request at RESET_PC follows.
